bip_report_tx: RTL and testbench
================================

# bip_report_tx

Run controller and result transmitter for the BIP processor. It gates the CPU's `i_valid` to start and stop a program run, and counts executed cycles. When the fetched instruction is HLT it freezes the CPU and snapshots PC and ACC, then serializes an 8-byte report frame into a byte-wide UART transmitter through a start/done handshake. It sits between the BIP top-level outputs (`o_pc`, `o_acc`, `o_instruction`) and the UART TX, and is the outbound end of the BIP debug link.

## Interface
Parameters:
- `NB_DATA`, 16, instruction/ACC width
- `NB_OPCODE`, 5, opcode field width (instruction MSBs)
- `LOG2_N_INSMEM_ADDR`, 11, PC width (≤16)
- `NB_CYCLES`, 16, cycle counter width
- `NB_BYTE`, 8, UART byte width

Ports:
- `i_clock`  in  1  single clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_start`  in  1  one-cycle pulse, begin a run
- `i_pc`  in  LOG2_N_INSMEM_ADDR  BIP program counter
- `i_acc`  in  NB_DATA  BIP accumulator
- `i_instruction`  in  NB_DATA  currently fetched instruction
- `i_tx_done`  in  1  one-cycle pulse, UART finished current byte
- `o_cpu_valid`  out  1  enable to BIP `i_valid`
- `o_tx_data`  out  NB_BYTE  byte to UART
- `o_tx_start`  out  1  one-cycle pulse, UART load `o_tx_data`
- `o_busy`  out  1  run or transmission in progress
- `o_done`  out  1  frame fully sent, held until next start/reset

## Operation
- States: IDLE, RUN, SEND, WAIT, DONE.
- IDLE/DONE + `i_start`: go to RUN, clear cycle counter, clear `o_done`. `i_start` is ignored in RUN/SEND/WAIT.
- RUN: `o_cpu_valid = (state==RUN) && (opcode != HLT_OPCODE)`. This is combinational, so the CPU does not advance on the HLT cycle.
- The counter increments on every cycle with `o_cpu_valid=1` and saturates at all-ones without wrapping.
- HLT seen in RUN: the same clock edge latches PC (zero-extended to 16 bits), ACC and the counter, sets byte index to 0, and goes to SEND.
- Frame order: `0xA5`, PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], CYC[15:8], CYC[7:0], CHK. CHK is the XOR of bytes 1–6.
  - For `NB_CYCLES>16`, the upper 16 bits of the saturated counter are sent.
- SEND: drive `o_tx_data` = frame[index] and pulse `o_tx_start` for one cycle, then go to WAIT.
- WAIT: on `i_tx_done`, if index==7 go to DONE, else increment index and go to SEND.
  - `i_tx_done` is ignored in any other state.
- DONE: `o_done=1`, `o_cpu_valid=0`.
- `o_busy = 1` in RUN, SEND and WAIT.

## Timing
- Reset values: state IDLE, all outputs 0, counter 0, index 0. Reset mid-run or mid-frame aborts immediately, and no further `o_tx_start` pulses are issued.
- Latency from the HLT cycle:
  - `o_tx_start` for byte 0 asserts 1 cycle later.
  - Each following byte's `o_tx_start` asserts 1 cycle after the previous byte's `i_tx_done`.
- `o_tx_data` is stable from the `o_tx_start` cycle until `i_tx_done`.
- `o_done` asserts the cycle after the 8th `i_tx_done`.
- HLT at the first RUN cycle: count = 0 and the frame is still sent.
- `i_start` and `i_tx_done` in the same cycle while in WAIT: `i_tx_done` is honoured and `i_start` is dropped.

## Structure
- Shared package `bip_pkg` holds `HLT_OPCODE = 5'b00000`, `FRAME_HEADER = 8'hA5`, `FRAME_LEN = 8`, and the state encoding typedef.
- No sub-module is needed. One counter, one frame mux and the FSM live in a single module.
- The top level instantiates it beside `bip_BIP` and a UART TX.

## Test plan
- Program `LDI 7; NOP; NOP; HLT`, start pulse, UART done 10 cycles after each start.
  - Required frame: A5 00 03 00 07 00 03 07.
  - `o_done` asserts after the 8th done.
- HLT at address 0: frame A5 00 00 00 00 00 00 00.
  - `o_cpu_valid` never asserts.
- Counter saturation with `NB_CYCLES=4` and a 20-instruction program before HLT: CYC bytes 00 0F.
- Reset asserted after the 3rd `i_tx_done`:
  - Outputs are 0 the next cycle.
  - No further `o_tx_start` pulses.
  - A new `i_start` produces a full frame from byte 0.
- Spurious `i_tx_done` in RUN, and `i_start` during WAIT: both ignored, and the frame is unchanged.
- `i_tx_done` held 0 for 1000 cycles in WAIT: `o_tx_data` is stable and no extra `o_tx_start` pulse is issued.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared constants and state encoding for the BIP run controller and its
// outbound debug report frame.
package bip_pkg;

    localparam logic [4:0] HLT_OPCODE   = 5'b00000;
    localparam logic [7:0] FRAME_HEADER = 8'hA5;
    localparam int         FRAME_LEN    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bip_report_tx.sv
// Gates the BIP CPU for one program run, counts executed cycles, and on HLT
// sends an 8-byte PC/ACC/cycle report through a byte-wide UART handshake.
module bip_report_tx
    import bip_pkg::*;
#(
    parameter int NB_DATA            = 16,
    parameter int NB_OPCODE          = 5,
    parameter int LOG2_N_INSMEM_ADDR = 11,
    parameter int NB_CYCLES          = 16,
    parameter int NB_BYTE            = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0]            i_acc,
    input  logic [NB_DATA-1:0]            i_instruction,
    input  logic                          i_tx_done,
    output logic                          o_cpu_valid,
    output logic [NB_BYTE-1:0]            o_tx_data,
    output logic                          o_tx_start,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int                NB_INDEX   = $clog2(FRAME_LEN);
    localparam logic [NB_INDEX-1:0] LAST_INDEX = NB_INDEX'(FRAME_LEN - 1);

    state_t               state;
    logic [NB_CYCLES-1:0] cycles;
    logic [NB_INDEX-1:0]  index;
    logic [NB_INDEX-1:0]  mux_index;
    logic [15:0]          pc_snap;
    logic [15:0]          acc_snap;
    logic [15:0]          cyc_snap;
    logic [15:0]          cyc16;
    logic [7:0]           frame_byte;
    logic                 is_hlt;
    logic                 unused_bits;

    assign is_hlt      = i_instruction[NB_DATA-1 -: NB_OPCODE] == NB_OPCODE'(HLT_OPCODE);
    assign unused_bits = ^i_instruction[NB_DATA-NB_OPCODE-1:0];

    // Combinational on purpose: the CPU must not advance on the HLT cycle.
    assign o_cpu_valid = (state == ST_RUN) && !is_hlt;
    assign o_busy      = (state == ST_RUN) || (state == ST_SEND) || (state == ST_WAIT);
    assign o_done      = (state == ST_DONE);

    // Wide counters report their upper 16 bits; narrow ones are zero-extended.
    if (NB_CYCLES >= 16) begin : g_cyc_wide
        assign cyc16 = cycles[NB_CYCLES-1 -: 16];
    end else begin : g_cyc_narrow
        assign cyc16 = 16'(cycles);
    end

    // Byte 0 is loaded straight from the HLT cycle, later bytes on each done.
    assign mux_index = (state == ST_WAIT) ? NB_INDEX'(index + 1'b1) : '0;

    // NOTE: every path assigns frame_byte first, so no latch can be inferred.
    always_comb begin
        frame_byte = FRAME_HEADER;
        case (mux_index)
            3'd1:    frame_byte = pc_snap[15:8];
            3'd2:    frame_byte = pc_snap[7:0];
            3'd3:    frame_byte = acc_snap[15:8];
            3'd4:    frame_byte = acc_snap[7:0];
            3'd5:    frame_byte = cyc_snap[15:8];
            3'd6:    frame_byte = cyc_snap[7:0];
            3'd7:    frame_byte = pc_snap[15:8] ^ pc_snap[7:0] ^ acc_snap[15:8]
                                ^ acc_snap[7:0] ^ cyc_snap[15:8] ^ cyc_snap[7:0];
            default: frame_byte = FRAME_HEADER;
        endcase
    end

    // NOTE: all state updates use <= so every branch sees pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            cycles     <= '0;
            index      <= '0;
            pc_snap    <= '0;
            acc_snap   <= '0;
            cyc_snap   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            if (o_cpu_valid && (cycles != '1))
                cycles <= cycles + 1'b1;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state  <= ST_RUN;
                        cycles <= '0;
                    end
                end
                ST_RUN: begin
                    if (is_hlt) begin
                        pc_snap    <= 16'(i_pc);
                        acc_snap   <= 16'(i_acc);
                        cyc_snap   <= cyc16;
                        index      <= '0;
                        o_tx_data  <= NB_BYTE'(frame_byte);
                        o_tx_start <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: state <= ST_WAIT;
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (index == LAST_INDEX) begin
                            state <= ST_DONE;
                        end else begin
                            index      <= index + 1'b1;
                            o_tx_data  <= NB_BYTE'(frame_byte);
                            o_tx_start <= 1'b1;
                            state      <= ST_SEND;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_report_tx.sv
// Directed bench: a tiny CPU model runs LDI/NOP/HLT programs while a UART
// responder acknowledges bytes; frames are compared against hand-computed tables.
module tb_bip_report_tx;

    localparam logic [4:0] OP_LDI = 5'b00011;
    localparam logic [4:0] OP_NOP = 5'b11111;

    typedef struct {
        logic        has_ldi;
        logic [10:0] imm;
        int          nops;
        int          delay;
        logic        disturb;
        logic [63:0] exp;
        logic [63:0] exp_sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        tx_done;
    logic        cpu_rst;
    logic [10:0] cpu_pc;
    logic [15:0] cpu_acc;
    logic [15:0] instr;
    logic [15:0] prog [2048];

    logic        cpu_valid, tx_start, busy, done;
    logic [7:0]  tx_data;
    logic        sat_cpu_valid, sat_tx_start, sat_busy, sat_done;
    logic [7:0]  sat_tx_data;

    int checks   = 0;
    int failures = 0;
    int n_starts = 0;

    always #5 clk = ~clk;

    assign instr = prog[cpu_pc];

    bip_report_tx dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_pc(cpu_pc),
        .i_acc(cpu_acc), .i_instruction(instr), .i_tx_done(tx_done),
        .o_cpu_valid(cpu_valid), .o_tx_data(tx_data), .o_tx_start(tx_start),
        .o_busy(busy), .o_done(done)
    );

    bip_report_tx #(.NB_CYCLES(4)) dut_sat (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_pc(cpu_pc),
        .i_acc(cpu_acc), .i_instruction(instr), .i_tx_done(tx_done),
        .o_cpu_valid(sat_cpu_valid), .o_tx_data(sat_tx_data), .o_tx_start(sat_tx_start),
        .o_busy(sat_busy), .o_done(sat_done)
    );

    // Minimal CPU: advances only while enabled; LDI loads an 11-bit immediate.
    always @(posedge clk) begin
        if (rst || cpu_rst) begin
            cpu_pc  <= '0;
            cpu_acc <= '0;
        end else if (cpu_valid) begin
            cpu_pc <= cpu_pc + 1'b1;
            if (instr[15:11] == OP_LDI)
                cpu_acc <= {5'b0, instr[10:0]};
        end
    end

    always @(negedge clk) if (tx_start) n_starts++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_program(input vec_t v);
        int a;
        for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
        a = 0;
        if (v.has_ldi) begin
            prog[0] = {OP_LDI, v.imm};
            a = 1;
        end
        for (int i = 0; i < v.nops; i++) prog[a + i] = {OP_NOP, 11'd0};
        @(posedge clk); #1 cpu_rst = 1'b1;
        @(posedge clk); #1 cpu_rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Acknowledges n_ack bytes; returns at posedge+1 after the last ack edge.
    task automatic run_frame(input int delay, input int n_ack, input logic disturb,
                             output logic [63:0] got, output logic [63:0] got_sat,
                             output logic stable_ok);
        int waited;
        logic [7:0] b_v;
        got       = '0;
        got_sat   = '0;
        stable_ok = 1'b1;
        for (int b = 0; b < n_ack; b++) begin
            waited = 0;
            @(negedge clk);
            while (!tx_start && waited < 3000) begin
                @(negedge clk);
                waited++;
            end
            if (!tx_start) begin
                check($sformatf("start_timeout_byte%0d", b), 1, 0);
                return;
            end
            if (b > 0) check($sformatf("start_latency_byte%0d", b), 64'(waited), 0);
            b_v = tx_data;
            got[63-8*b -: 8]     = b_v;
            got_sat[63-8*b -: 8] = sat_tx_data;
            for (int k = 0; k < delay; k++) begin
                @(negedge clk);
                if (tx_data !== b_v || tx_start !== 1'b0) stable_ok = 1'b0;
                if (disturb && b == 2 && k == 1) start = 1'b1;
                if (disturb && b == 2 && k == 2) start = 1'b0;
            end
            @(posedge clk); #1;
            tx_done = 1'b1;
            if (disturb && b == 4) start = 1'b1;
            @(negedge clk);
            if (tx_data !== b_v || tx_start !== 1'b0) stable_ok = 1'b0;
            @(posedge clk); #1;
            tx_done = 1'b0;
            start   = 1'b0;
        end
    endtask

    vec_t        vecs [5];
    logic [63:0] got, got_sat;
    logic        stable_ok;
    int          s0;

    initial begin
        vecs[0] = '{1'b1, 11'h007,   2,   10, 1'b0,
                    64'hA5_00_03_00_07_00_03_07, 64'hA5_00_03_00_07_00_03_07};
        vecs[1] = '{1'b0, 11'h000,   0,    3, 1'b0,
                    64'hA5_00_00_00_00_00_00_00, 64'hA5_00_00_00_00_00_00_00};
        vecs[2] = '{1'b1, 11'h234,   5, 1000, 1'b0,
                    64'hA5_00_06_02_34_00_06_36, 64'hA5_00_06_02_34_00_06_36};
        vecs[3] = '{1'b1, 11'h7FF, 300,    2, 1'b0,
                    64'hA5_01_2D_07_FF_01_2D_F8, 64'hA5_01_2D_07_FF_00_0F_DB};
        vecs[4] = '{1'b1, 11'h055,  19,    4, 1'b1,
                    64'hA5_00_14_00_55_00_14_55, 64'hA5_00_14_00_55_00_0F_4E};

        rst     = 1'b1;
        start   = 1'b0;
        tx_done = 1'b0;
        cpu_rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {cpu_valid, tx_start, busy, done, tx_data}, '0);
        @(posedge clk); #1 rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            load_program(vecs[v]);
            s0 = n_starts;
            pulse_start();
            @(negedge clk);
            check($sformatf("v%0d_run_entry_busy_done", v), {busy, done}, 2'b10);
            if (vecs[v].disturb) begin
                for (int k = 0; k < 4; k++) begin
                    tx_done = (k % 2 == 0);
                    @(negedge clk);
                end
                tx_done = 1'b0;
            end
            run_frame(vecs[v].delay, 8, vecs[v].disturb, got, got_sat, stable_ok);
            for (int b = 0; b < 8; b++) begin
                check($sformatf("v%0d_byte%0d", v, b), got[63-8*b -: 8], vecs[v].exp[63-8*b -: 8]);
                check($sformatf("v%0d_sat_byte%0d", v, b), got_sat[63-8*b -: 8],
                      vecs[v].exp_sat[63-8*b -: 8]);
            end
            check($sformatf("v%0d_data_stable", v), stable_ok, 1'b1);
            @(negedge clk);
            check($sformatf("v%0d_done_flag", v), {done, busy}, 2'b10);
            check($sformatf("v%0d_start_pulses", v), 64'(n_starts - s0), 8);
            check($sformatf("v%0d_final_pc", v), cpu_pc,
                  64'(vecs[v].nops + int'(vecs[v].has_ldi)));
        end

        // Reset in the middle of a frame, then a clean rerun.
        load_program(vecs[0]);
        pulse_start();
        run_frame(5, 3, 1'b0, got, got_sat, stable_ok);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midframe_reset_outputs", {cpu_valid, tx_start, busy, done, tx_data}, '0);
        s0 = n_starts;
        @(posedge clk); #1 rst = 1'b0;
        repeat (50) @(negedge clk);
        check("no_start_after_reset", 64'(n_starts - s0), 0);
        s0 = n_starts;
        pulse_start();
        run_frame(3, 8, 1'b0, got, got_sat, stable_ok);
        check("rerun_frame", got, vecs[0].exp);
        @(negedge clk);
        check("rerun_done_flag", {done, busy}, 2'b10);
        check("rerun_start_pulses", 64'(n_starts - s0), 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
